ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_frame_rx.sv | 133 +++++++++++++
 rtl/ps2_key_decoder.sv | 65 ++++++
 tb/tb_ps2_key_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and key decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  localparam logic [7:0]  BREAK_CODE             = 8'hF0;
  localparam logic [7:0]  EXT_CODE               = 8'hE0;
  localparam int unsigned DEFAULT_CLK_HZ         = 100_000_000;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = DEFAULT_CLK_HZ / 1000;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizer, PS2Clk glitch filter, 11-bit frame FSM, idle timeout.
// Odd-parity checking is compiled in when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] data_o,
  output logic       data_valid_c_o,
  output logic       frame_error_o
);

  localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  logic [1:0]   clk_sync_q;
  logic [1:0]   data_sync_q;
  logic [FW-1:0] fcnt_q;
  logic          filt_q;
  logic          filt_prev_q;
  frame_state_e  state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bitcnt_q;
  logic          parity_q;
  logic [TW-1:0] tmo_q;
  logic          error_q;

  logic strobe_c;
  logic tmo_hit_c;
  logic parity_ok_c;
  logic frame_ok_c;

  assign strobe_c    = filt_prev_q & ~filt_q;
  assign tmo_hit_c   = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign parity_ok_c = ^{shift_q, parity_q};
  assign frame_ok_c  = data_sync_q[1] & (parity_ok_c | ~PARITY_CHECK);

  // Two-flop synchronizers; both lines idle high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  // Filtered level flips only after FILTER_CYCLES consecutive differing samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fcnt_q      <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_sync_q[1] == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_CYCLES - 1)) begin
        filt_q <= clk_sync_q[1];
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      parity_q <= 1'b0;
      tmo_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      error_q <= 1'b0;

      // Idle timer only runs inside a frame and is cleared by every strobe.
      if (state_q != ST_IDLE && !strobe_c) begin
        if (tmo_hit_c) begin
          state_q <= ST_IDLE;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end else begin
        tmo_q <= '0;
      end

      if (strobe_c) begin
        case (state_q)
          ST_IDLE: begin
            if (!data_sync_q[1]) begin
              state_q  <= ST_DATA;
              bitcnt_q <= '0;
            end
          end
          ST_DATA: begin
            shift_q  <= {data_sync_q[1], shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_q <= data_sync_q[1];
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            error_q <= ~frame_ok_c;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_o         = shift_q;
  assign data_valid_c_o = strobe_c & (state_q == ST_STOP) & frame_ok_c;
  assign frame_error_o  = error_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: tracks the last pressed key and its held state from make/break codes.
// Optional odd-parity checking in the receiver is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEFAULT_CLK_HZ,
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 1000
) (
  input  logic       Clock,
  input  logic       btnCpuReset,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] KeyCode,
  output logic       Enable,
  output logic       FrameError
);

  logic [7:0] rx_data;
  logic       rx_valid_c;
  logic       rx_error;

  logic [7:0] key_q;
  logic       enable_q;
  logic       break_q;

  ps2_frame_rx #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i         (Clock),
    .rst_ni        (btnCpuReset),
    .ps2_clk_i     (PS2Clk),
    .ps2_data_i    (PS2Data),
    .data_o        (rx_data),
    .data_valid_c_o(rx_valid_c),
    .frame_error_o (rx_error)
  );

  // Release only clears Enable when it names the key currently shown.
  always_ff @(posedge Clock or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      key_q    <= 8'h00;
      enable_q <= 1'b0;
      break_q  <= 1'b0;
    end else if (rx_valid_c) begin
      if (rx_data == BREAK_CODE) begin
        break_q <= 1'b1;
      end else if (rx_data == EXT_CODE) begin
        break_q <= break_q;
      end else if (!break_q) begin
        key_q    <= rx_data;
        enable_q <= 1'b1;
      end else begin
        if (rx_data == key_q) enable_q <= 1'b0;
        break_q <= 1'b0;
      end
    end
  end

  assign KeyCode    = key_q;
  assign Enable     = enable_q;
  assign FrameError = rx_error;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder (short timeout for simulation speed).
module tb_ps2_key_decoder;

  localparam int unsigned TMO  = 200;
  localparam int unsigned HALF = 20;

  logic       Clock;
  logic       btnCpuReset;
  logic       PS2Clk;
  logic       PS2Data;
  logic [7:0] KeyCode;
  logic       Enable;
  logic       FrameError;

  int checks;
  int errors;
  int fe_count;
  int fe_run;
  int fe_max_run;

  ps2_key_decoder #(
    .CLK_HZ        (100_000_000),
    .FILTER_CYCLES (8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clock      (Clock),
    .btnCpuReset(btnCpuReset),
    .PS2Clk     (PS2Clk),
    .PS2Data    (PS2Data),
    .KeyCode    (KeyCode),
    .Enable     (Enable),
    .FrameError (FrameError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (FrameError === 1'b1) begin
      fe_count = fe_count + 1;
      fe_run   = fe_run + 1;
      if (fe_run > fe_max_run) fe_max_run = fe_run;
    end else begin
      fe_run = 0;
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge Clock);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic flip);
    logic par;
    par = ~(^d) ^ flip;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      PS2Data = frame[i];
      wait_cycles(HALF);
      PS2Clk = 1'b0;
      wait_cycles(HALF);
      PS2Clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic flip);
    send_bits(make_frame(d, flip), 11);
    PS2Data = 1'b1;
    wait_cycles(3 * HALF);
  endtask

  task automatic check_out(input string name, input logic [7:0] exp_key, input logic exp_en);
    checks++;
    if (KeyCode !== exp_key) begin
      errors++;
      $display("FAIL %s KeyCode: got %h expected %h", name, KeyCode, exp_key);
    end
    checks++;
    if (Enable !== exp_en) begin
      errors++;
      $display("FAIL %s Enable: got %b expected %b", name, Enable, exp_en);
    end
  endtask

  task automatic test_reset();
    wait_cycles(5);
    check_out("reset", 8'h00, 1'b0);
    checks++;
    if (FrameError !== 1'b0) begin
      errors++;
      $display("FAIL reset FrameError: got %b expected 0", FrameError);
    end
    btnCpuReset = 1'b1;
    wait_cycles(20);
  endtask

  task automatic test_make();
    int fe0;
    fe0 = fe_count;
    send_byte(8'h1C, 1'b0);
    check_out("make_1c", 8'h1C, 1'b1);
    checks++;
    if (fe_count !== fe0) begin
      errors++;
      $display("FAIL make_1c FrameError pulses: got %0d expected 0", fe_count - fe0);
    end
  endtask

  task automatic test_break();
    send_byte(8'hF0, 1'b0);
    check_out("break_prefix", 8'h1C, 1'b1);
    send_byte(8'h1C, 1'b0);
    check_out("break_1c", 8'h1C, 1'b0);
  endtask

  task automatic test_typematic();
    send_byte(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    check_out("typematic", 8'h1C, 1'b1);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    check_out("typematic_release", 8'h1C, 1'b0);
  endtask

  task automatic test_last_key_wins();
    send_byte(8'h1C, 1'b0);
    send_byte(8'h1B, 1'b0);
    check_out("second_key", 8'h1B, 1'b1);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    check_out("old_release_ignored", 8'h1B, 1'b1);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1B, 1'b0);
    check_out("new_release", 8'h1B, 1'b0);
  endtask

  task automatic test_ext_code();
    send_byte(8'hE0, 1'b0);
    check_out("ext_ignored", 8'h1B, 1'b0);
  endtask

  task automatic test_parity();
    int fe0;
    fe0 = fe_count;
    fe_max_run = 0;
    send_byte(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check_out("bad_parity", 8'h1B, 1'b0);
    checks++;
    if (fe_count - fe0 !== 1) begin
      errors++;
      $display("FAIL bad_parity FrameError cycles: got %0d expected 1", fe_count - fe0);
    end
    checks++;
    if (fe_max_run !== 1) begin
      errors++;
      $display("FAIL bad_parity pulse width: got %0d expected 1", fe_max_run);
    end
`else
    check_out("parity_ignored", 8'h1C, 1'b1);
    checks++;
    if (fe_count !== fe0) begin
      errors++;
      $display("FAIL parity_ignored FrameError cycles: got %0d expected 0", fe_count - fe0);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    check_out("parity_ignored_release", 8'h1C, 1'b0);
`endif
  endtask

  task automatic test_timeout();
    int fe0;
    fe0 = fe_count;
    send_bits(make_frame(8'h23, 1'b0), 5);
    PS2Data = 1'b1;
    wait_cycles(TMO + 10);
    send_byte(8'h23, 1'b0);
    check_out("after_timeout", 8'h23, 1'b1);
    checks++;
    if (fe_count !== fe0) begin
      errors++;
      $display("FAIL timeout FrameError cycles: got %0d expected 0", fe_count - fe0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] f;
    f = make_frame(8'h1C, 1'b0);
    send_bits(f, 5);
    PS2Data = f[5];
    wait_cycles(HALF);
    PS2Clk = 1'b0;
    wait_cycles(HALF / 2);
    btnCpuReset = 1'b0;
    wait_cycles(2);
    check_out("midframe_reset", 8'h00, 1'b0);
    checks++;
    if (FrameError !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset FrameError: got %b expected 0", FrameError);
    end
    PS2Clk  = 1'b1;
    PS2Data = 1'b1;
    wait_cycles(5);
    btnCpuReset = 1'b1;
    wait_cycles(40);
    send_byte(8'h2B, 1'b0);
    check_out("after_reset", 8'h2B, 1'b1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    fe_count    = 0;
    fe_run      = 0;
    fe_max_run  = 0;
    btnCpuReset = 1'b0;
    PS2Clk      = 1'b1;
    PS2Data     = 1'b1;

    test_reset();
    test_make();
    test_break();
    test_typematic();
    test_last_key_wins();
    test_ext_code();
    test_parity();
    test_timeout();
    test_reset_midframe();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
